inv_mix_state: RTL and testbench

//   Sequential AES InvMixColumns over a full 128-bit state, for the decryption datapath.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/inv_mix_col.sv | 61 ++++++
 rtl/inv_mix_state.sv | 115 +++++++++++
 tb/tb_inv_mix_state.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES InvMixColumns definitions: GF(2^8) helpers, matrix coefficients, FSM states.
// Forward coefficients are only consumed when INV_MIX_FWD_EN is defined.
package aes_pkg;

    localparam logic [7:0] INV_C0 = 8'h0e;
    localparam logic [7:0] INV_C1 = 8'h0b;
    localparam logic [7:0] INV_C2 = 8'h0d;
    localparam logic [7:0] INV_C3 = 8'h09;

    localparam logic [7:0] FWD_C0 = 8'h02;
    localparam logic [7:0] FWD_C1 = 8'h03;
    localparam logic [7:0] FWD_C2 = 8'h01;
    localparam logic [7:0] FWD_C3 = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mix_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply from precomputed xtime terms; coefficients here never exceed 4 bits.
    function automatic logic [7:0] gf_comb(input logic [3:0] c, input logic [7:0] a,
                                           input logic [7:0] x2, input logic [7:0] x4,
                                           input logic [7:0] x8);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    function automatic logic [31:0] col_slice(input logic [127:0] s, input logic [1:0] idx);
        return s[127 - 32*idx -: 32];
    endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational single-column InvMixColumns; with INV_MIX_FWD_EN defined, fwd_i selects
// forward MixColumns reusing the same xtime terms.
module inv_mix_col
    import aes_pkg::*;
(
`ifdef INV_MIX_FWD_EN
    input  logic        fwd_i,
`endif
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [3:0][7:0] a, x2, x4, x8, inv_b;
`ifdef INV_MIX_FWD_EN
    logic [3:0][7:0] fwd_b;
`endif
    logic [1:0] r1, r2, r3;

    always_comb begin
        a     = '0;
        x2    = '0;
        x4    = '0;
        x8    = '0;
        inv_b = '0;
`ifdef INV_MIX_FWD_EN
        fwd_b = '0;
`endif
        r1    = '0;
        r2    = '0;
        r3    = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            a[r]  = col_i[31 - 8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int unsigned r = 0; r < 4; r++) begin
            r1 = 2'(r + 1);
            r2 = 2'(r + 2);
            r3 = 2'(r + 3);
            inv_b[r] = gf_comb(INV_C0[3:0], a[r],  x2[r],  x4[r],  x8[r])
                     ^ gf_comb(INV_C1[3:0], a[r1], x2[r1], x4[r1], x8[r1])
                     ^ gf_comb(INV_C2[3:0], a[r2], x2[r2], x4[r2], x8[r2])
                     ^ gf_comb(INV_C3[3:0], a[r3], x2[r3], x4[r3], x8[r3]);
`ifdef INV_MIX_FWD_EN
            fwd_b[r] = gf_comb(FWD_C0[3:0], a[r],  x2[r],  x4[r],  x8[r])
                     ^ gf_comb(FWD_C1[3:0], a[r1], x2[r1], x4[r1], x8[r1])
                     ^ gf_comb(FWD_C2[3:0], a[r2], x2[r2], x4[r2], x8[r2])
                     ^ gf_comb(FWD_C3[3:0], a[r3], x2[r3], x4[r3], x8[r3]);
`endif
        end
    end

`ifdef INV_MIX_FWD_EN
    assign col_o = fwd_i ? {fwd_b[0], fwd_b[1], fwd_b[2], fwd_b[3]}
                         : {inv_b[0], inv_b[1], inv_b[2], inv_b[3]};
`else
    assign col_o = {inv_b[0], inv_b[1], inv_b[2], inv_b[3]};
`endif

endmodule

// File: rtl/inv_mix_state.sv
// Iterative InvMixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per busy cycle.
// Defining INV_MIX_FWD_EN adds a fwd port selecting forward MixColumns per accepted state.
module inv_mix_state
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef INV_MIX_FWD_EN
    input  logic         fwd,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gen_bad_cfg
        $error("inv_mix_state: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // A step of 4 wraps to 0, so the single group is always the last one.
    localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LastIdx = 2'(4 - COLS_PER_CYCLE);

    mix_state_e   state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [127:0] work_q, work_d;
`ifdef INV_MIX_FWD_EN
    logic         fwd_q, fwd_d;
`endif

    logic [1:0]  grp_idx[COLS_PER_CYCLE];
    logic [31:0] grp_in[COLS_PER_CYCLE];
    logic [31:0] grp_out[COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gen_col
        assign grp_idx[g] = col_idx_q + 2'(g);
        assign grp_in[g]  = col_slice(work_q, grp_idx[g]);

        inv_mix_col u_col (
`ifdef INV_MIX_FWD_EN
            .fwd_i (fwd_q),
`endif
            .col_i (grp_in[g]),
            .col_o (grp_out[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
`ifdef INV_MIX_FWD_EN
        fwd_d     = fwd_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_d[127 - 32*grp_idx[g] -: 32] = grp_out[g];
                end
                col_idx_d = col_idx_q + ColStep;
                if (col_idx_q == LastIdx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the DONE->IDLE exit, giving back-to-back operation.
        if (in_valid && in_ready) begin
            work_d    = in_data;
            col_idx_d = '0;
            state_d   = BUSY;
`ifdef INV_MIX_FWD_EN
            fwd_d     = fwd;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_idx_q <= '0;
            work_q    <= '0;
`ifdef INV_MIX_FWD_EN
            fwd_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
`ifdef INV_MIX_FWD_EN
            fwd_q     <= fwd_d;
`endif
        end
    end

    assign out_data = work_q;

endmodule

// File: tb/tb_inv_mix_state.sv
// Scoreboard bench for inv_mix_state at COLS_PER_CYCLE = 1, 2 and 4; fwd tests need INV_MIX_FWD_EN.
module tb_inv_mix_state;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst[3];
    logic         in_valid[3];
    logic         in_ready[3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic [127:0] out_data[3];
    logic [127:0] in_data = '0;
`ifdef INV_MIX_FWD_EN
    logic         fwd = 1'b0;
`endif

    for (genvar k = 0; k < 3; k++) begin : gen_dut
        inv_mix_state #(.COLS_PER_CYCLE(1 << k)) u_dut (
            .clk       (clk),
            .rst       (rst[k]),
`ifdef INV_MIX_FWD_EN
            .fwd       (fwd),
`endif
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_data   (in_data),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k])
        );
    end

    int unsigned total = 0;
    int unsigned bad = 0;
    int          cur = 0;
    int unsigned lat = 4;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] exp_q[$];
    int unsigned  acc_q[$];
    int unsigned  timeouts = 0, to_seen = 0;
    int unsigned  idle_req = 0, idle_seen = 0;
    bit           gap_chk = 1'b0;

    // Hand-computed InvMixColumns column pairs: cout[i] = InvMix(cin[i]).
    logic [31:0] cin[6];
    logic [31:0] cout[6];

    function automatic logic [127:0] st(input int a, input int b, input int c, input int d,
                                        input bit o);
        return o ? {cout[a], cout[b], cout[c], cout[d]} : {cin[a], cin[b], cin[c], cin[d]};
    endfunction

`ifdef INV_MIX_FWD_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s, input bit f);
        logic [7:0]   m[4];
        logic [7:0]   a[4];
        logic [7:0]   b;
        logic [127:0] r = '0;
        if (f) m = '{8'h02, 8'h03, 8'h01, 8'h01};
        else   m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b ^= gmul(a[(i + j) % 4], m[j]);
                r[127 - 32*c - 8*i -: 8] = b;
            end
        end
        return r;
    endfunction
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cols/cycle=%0d): got %h, want %h", name, 1 << cur, act, exp);
        end
    endtask

    // Monitor: every comparison happens here, on the falling edge.
    bit          prev_ov = 1'b0, prev_hold = 1'b0, have_rise = 1'b0;
    int unsigned last_rise = 0;
    always @(negedge clk) begin : mon
        logic ov, ordy, ir, rs;
        logic [127:0] od;
        ov = out_valid[cur]; ordy = out_ready[cur]; ir = in_ready[cur];
        rs = rst[cur]; od = out_data[cur];
        if (timeouts != to_seen) begin
            chk("wait_bound_expired", 128'(timeouts - to_seen), 128'd0);
            to_seen = timeouts;
        end
        if (!gap_chk) have_rise = 1'b0;
        if (!rs) begin
            if (idle_req != idle_seen) begin
                idle_seen = idle_req;
                chk("idle_out_valid", {127'd0, ov}, 128'd0);
                chk("idle_in_ready", {127'd0, ir}, 128'd1);
                chk("idle_out_data", od, 128'd0);
            end
            if (prev_hold) chk("valid_held", {127'd0, ov}, 128'd1);
            if (ov && exp_q.size() == 0) begin
                chk("unexpected_out", {127'd0, ov}, 128'd0);
            end else if (ov) begin
                if (!prev_ov) begin
                    chk("latency", 128'(cyc - acc_q[0]), 128'(lat));
                    if (gap_chk && have_rise) chk("stream_gap", 128'(cyc - last_rise), 128'(lat + 1));
                    last_rise = cyc;
                    have_rise = gap_chk;
                end
                chk("out_data", od, exp_q[0]);
                if (!ordy) chk("in_ready_backpressure", {127'd0, ir}, 128'd0);
                if (ordy && in_valid[cur]) chk("b2b_in_ready", {127'd0, ir}, 128'd1);
                if (ordy) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
        end
        prev_ov   = ov && !rs;
        prev_hold = ov && !ordy && !rs;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push);
        int n = 0;
        logic acc = 1'b0;
        in_data = d;
        in_valid[cur] = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready[cur];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid[cur] = 1'b0;
        if (!acc) timeouts++;
        else if (push) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid[cur] && n < 50) begin
            wait_cycles(1);
            n++;
        end
        if (!out_valid[cur]) timeouts++;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            wait_cycles(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeouts++;
            exp_q.delete();
            acc_q.delete();
        end
        wait_cycles(1);
    endtask

    task automatic do_reset();
        rst[cur] = 1'b1;
        wait_cycles(2);
        rst[cur] = 1'b0;
        idle_req++;
        wait_cycles(1);
    endtask

    initial begin
        cin[0] = 32'h8e4da1bc; cout[0] = 32'hdb135345;
        cin[1] = 32'h9fdc589d; cout[1] = 32'hf20a225c;
        cin[2] = 32'h01010101; cout[2] = 32'h01010101;
        cin[3] = 32'hc6c6c6c6; cout[3] = 32'hc6c6c6c6;
        cin[4] = 32'hd5d5d7d6; cout[4] = 32'hd4d4d4d5;
        cin[5] = 32'h4d7ebdf8; cout[5] = 32'h2d26314c;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        end

        for (int k = 0; k < 3; k++) begin
            cur = k;
            lat = 4 >> k;
            do_reset();

            send(st(0, 1, 2, 3, 0), st(0, 1, 2, 3, 1), 1'b1);
            drain();
            send(st(4, 5, 0, 5, 0), st(4, 5, 0, 5, 1), 1'b1);
            drain();

            // Backpressure, then release together with a new input.
            out_ready[cur] = 1'b0;
            send(st(1, 0, 3, 2, 0), st(1, 0, 3, 2, 1), 1'b1);
            wait_ov();
            wait_cycles(10);
            out_ready[cur] = 1'b1;
            send(st(5, 4, 1, 0, 0), st(5, 4, 1, 0, 1), 1'b1);
            drain();

            gap_chk = 1'b1;
            for (int i = 0; i < 8; i++) begin
                send(st(i % 6, (i + 1) % 6, (i + 2) % 6, (i + 3) % 6, 0),
                     st(i % 6, (i + 1) % 6, (i + 2) % 6, (i + 3) % 6, 1), 1'b1);
            end
            drain();
            gap_chk = 1'b0;

            // Abort while col_idx == 2 (col_idx stays 0 with four columns per cycle).
            send(st(2, 3, 4, 5, 0), '0, 1'b0);
            wait_cycles((k == 2) ? 0 : (2 >> k));
            rst[cur] = 1'b1;
            wait_cycles(1);
            rst[cur] = 1'b0;
            idle_req++;
            wait_cycles(8);
            send(st(3, 2, 5, 4, 0), st(3, 2, 5, 4, 1), 1'b1);
            drain();

`ifdef INV_MIX_FWD_EN
            fwd = 1'b1;
            send(st(0, 1, 4, 5, 1), st(0, 1, 4, 5, 0), 1'b1);
            fwd = 1'b0;
            send(st(0, 1, 4, 5, 0), st(0, 1, 4, 5, 1), 1'b1);
            drain();
            if (k == 2) begin
                for (int i = 0; i < 1000; i++) begin
                    logic [127:0] x, y;
                    x = {$urandom(), $urandom(), $urandom(), $urandom()};
                    y = model_state(x, 1'b1);
                    fwd = 1'b1;
                    send(x, y, 1'b1);
                    fwd = 1'b0;
                    send(y, x, 1'b1);
                end
                drain();
            end
`endif
            rst[cur] = 1'b1;
            wait_cycles(1);
        end

        wait_cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
